// File: rtl/tim_deadtime_if.sv
// tim_deadtime_if
//   Bundles the control inputs and drive outputs of the tim_deadtime
//   stage. DT_WIDTH must match the DT_WIDTH of the attached stage.
//
//   Signals:
//     enable     stage active (0 = both outputs low)
//     pwm_in     reference PWM level from the tim channel
//     dead_time  both-off window length in clk cycles (0 = none)
//     break_in   emergency stop, level-sensitive
//     break_clr  single-cycle pulse clearing a latched fault
//     out_p      high-side drive
//     out_n      low-side drive
//     dt_active  dead-time window running
//     fault      latched break indication
//
//   master: the controller side that drives enable/pwm_in/dead_time/break.
//   slave : the dead-time stage itself.
interface tim_deadtime_if #(
   parameter int unsigned DT_WIDTH = 8
);
   logic                enable;
   logic                pwm_in;
   logic [DT_WIDTH-1:0] dead_time;
   logic                break_in;
   logic                break_clr;
   logic                out_p;
   logic                out_n;
   logic                dt_active;
   logic                fault;

   modport master (
      output enable, pwm_in, dead_time, break_in, break_clr,
      input  out_p, out_n, dt_active, fault
   );

   modport slave (
      input  enable, pwm_in, dead_time, break_in, break_clr,
      output out_p, out_n, dt_active, fault
   );
endinterface

// File: rtl/tim_deadtime.sv
// tim_deadtime
//   Dead-time insertion stage following the tim PWM channel. Converts the
//   reference PWM level into a complementary high-side/low-side pair with
//   a programmable both-off window at every transition.
//
//   Ports:
//     clk  system clock, all logic on posedge
//     rst  synchronous active-high reset
//     bus  tim_deadtime_if.slave: enable, pwm_in, dead_time, break_in,
//          break_clr in; out_p, out_n, dt_active, fault out (registered)
//
//   Optional feature: define TIM_DEADTIME_BREAK_EN to compile in the break
//   input. When undefined, break_in/break_clr are ignored and fault stays 0.
module tim_deadtime #(
   parameter int unsigned DT_WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   tim_deadtime_if.slave bus
);

   localparam logic [2:0] ST_OFF   = 3'd0;
   localparam logic [2:0] ST_HIGH  = 3'd1;
   localparam logic [2:0] ST_LOW   = 3'd2;
   localparam logic [2:0] ST_DT    = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

   logic [2:0]          state, state_nx;
   logic [DT_WIDTH-1:0] cnt, cnt_nx;
   logic                target, target_nx;

   logic out_p_q, out_n_q, dt_active_q, fault_q;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      target_nx = target;

      case (state)
         ST_OFF: begin
            if (bus.enable) begin
               target_nx = bus.pwm_in;
               if (bus.dead_time == '0) begin
                  state_nx = bus.pwm_in ? ST_HIGH : ST_LOW;
               end else begin
                  state_nx = ST_DT;
                  cnt_nx   = bus.dead_time;
               end
            end
         end
         ST_HIGH: begin
            if (!bus.pwm_in) begin
               target_nx = 1'b0;
               if (bus.dead_time == '0) begin
                  state_nx = ST_LOW;
               end else begin
                  state_nx = ST_DT;
                  cnt_nx   = bus.dead_time;
               end
            end
         end
         ST_LOW: begin
            if (bus.pwm_in) begin
               target_nx = 1'b1;
               if (bus.dead_time == '0) begin
                  state_nx = ST_HIGH;
               end else begin
                  state_nx = ST_DT;
                  cnt_nx   = bus.dead_time;
               end
            end
         end
         ST_DT: begin
            // Target tracks pwm_in without reloading the counter, so a pulse
            // shorter than the window never reaches the outputs.
            target_nx = bus.pwm_in;
            if (cnt == DT_WIDTH'(1)) begin
               state_nx = target ? ST_HIGH : ST_LOW;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - DT_WIDTH'(1);
            end
         end
`ifdef TIM_DEADTIME_BREAK_EN
         ST_FAULT: begin
            if (bus.break_clr && !bus.break_in) begin
               state_nx = ST_OFF;
            end
         end
`endif
         default: begin
            state_nx = ST_OFF;
            cnt_nx   = '0;
         end
      endcase

      // enable=0 overrides any transition except while faulted.
      if (!bus.enable && state != ST_FAULT) begin
         state_nx = ST_OFF;
         cnt_nx   = '0;
      end

`ifdef TIM_DEADTIME_BREAK_EN
      if (bus.break_in) begin
         state_nx = ST_FAULT;
         cnt_nx   = '0;
      end
`endif
   end

`ifndef TIM_DEADTIME_BREAK_EN
   logic unused_break;
   assign unused_break = ^{bus.break_in, bus.break_clr};
`endif

   // Outputs are decoded from the next state and registered, so they change
   // on the same edge as the state and never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_OFF;
         cnt         <= '0;
         target      <= 1'b0;
         out_p_q     <= 1'b0;
         out_n_q     <= 1'b0;
         dt_active_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         target      <= target_nx;
         out_p_q     <= (state_nx == ST_HIGH);
         out_n_q     <= (state_nx == ST_LOW);
         dt_active_q <= (state_nx == ST_DT);
         fault_q     <= (state_nx == ST_FAULT);
      end
   end

   assign bus.out_p     = out_p_q;
   assign bus.out_n     = out_n_q;
   assign bus.dt_active = dt_active_q;
   assign bus.fault     = fault_q;

endmodule

// File: tb/tb_tim_deadtime.sv
// tb_tim_deadtime
//   Directed bench for tim_deadtime. A table of single-edge vectors covers
//   the basic window, short-pulse swallowing and enable handling; short
//   hand-written sequences cover zero dead time, mid-window dead_time
//   change, reset mid-window and the break input (when compiled in).
//   Expected outputs are packed as {out_p, out_n, dt_active, fault}.
module tb_tim_deadtime;

   logic clk;
   logic rst;

   tim_deadtime_if #(.DT_WIDTH(8)) bus ();

   tim_deadtime #(.DT_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst;
      logic       en;
      logic       pwm;
      logic [7:0] dt;
      logic [3:0] exp;
      string      name;
   } vec_t;

   vec_t tbl[$];
   int   vec_cnt  = 0;
   int   miss_cnt = 0;

   localparam logic [3:0] O_OFF  = 4'b0000;
   localparam logic [3:0] O_HIGH = 4'b1000;
   localparam logic [3:0] O_LOW  = 4'b0100;
   localparam logic [3:0] O_DT   = 4'b0010;
   localparam logic [3:0] O_FLT  = 4'b0001;

   task automatic add(input logic r, input logic e, input logic p,
                      input logic [7:0] d, input logic [3:0] x, input string n);
      vec_t v;
      v.rst = r; v.en = e; v.pwm = p; v.dt = d; v.exp = x; v.name = n;
      tbl.push_back(v);
   endtask

   // One active edge, then settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] exp);
      logic [3:0] act;
      act = {bus.out_p, bus.out_n, bus.dt_active, bus.fault};
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got {p,n,dt,f}=%b required %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic p, input logic [7:0] d);
      rst            = r;
      bus.enable     = e;
      bus.pwm_in     = p;
      bus.dead_time  = d;
   endtask

   initial begin
      rst           = 1'b1;
      bus.enable    = 1'b0;
      bus.pwm_in    = 1'b0;
      bus.dead_time = 8'd0;
      bus.break_in  = 1'b0;
      bus.break_clr = 1'b0;

      // basic window, dead_time = 3
      add(1, 0, 0, 3, O_OFF,  "reset");
      add(0, 0, 0, 3, O_OFF,  "off_hold");
      add(0, 1, 0, 3, O_DT,   "off_start_dt1");
      add(0, 1, 0, 3, O_DT,   "off_start_dt2");
      add(0, 1, 0, 3, O_DT,   "off_start_dt3");
      add(0, 1, 0, 3, O_LOW,  "enter_low");
      add(0, 1, 0, 3, O_LOW,  "low_hold");
      add(0, 1, 1, 3, O_DT,   "lh_n_falls_t");
      add(0, 1, 1, 3, O_DT,   "lh_dt2");
      add(0, 1, 1, 3, O_DT,   "lh_dt3");
      add(0, 1, 1, 3, O_HIGH, "lh_p_rises_t3");
      add(0, 1, 1, 3, O_HIGH, "high_hold");
      // back to LOW with dead_time = 5
      add(0, 1, 0, 5, O_DT,   "hl_dt1");
      add(0, 1, 0, 5, O_DT,   "hl_dt2");
      add(0, 1, 0, 5, O_DT,   "hl_dt3");
      add(0, 1, 0, 5, O_DT,   "hl_dt4");
      add(0, 1, 0, 5, O_DT,   "hl_dt5");
      add(0, 1, 0, 5, O_LOW,  "hl_low");
      // 2-cycle glitch while LOW, dead_time = 5
      add(0, 1, 1, 5, O_DT,   "glitch_dt1");
      add(0, 1, 1, 5, O_DT,   "glitch_dt2");
      add(0, 1, 0, 5, O_DT,   "glitch_dt3");
      add(0, 1, 0, 5, O_DT,   "glitch_dt4");
      add(0, 1, 0, 5, O_DT,   "glitch_dt5");
      add(0, 1, 0, 5, O_LOW,  "glitch_swallowed");
      // enable handling with dead_time = 0
      add(0, 1, 1, 0, O_HIGH, "dt0_low_to_high");
      add(0, 0, 1, 0, O_OFF,  "enable_drop_high");
      add(0, 1, 1, 0, O_HIGH, "dt0_off_to_high");
      add(0, 1, 0, 0, O_LOW,  "dt0_high_to_low");

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].pwm, tbl[i].dt);
         tick();
         check(tbl[i].name, tbl[i].exp);
      end

      // zero dead time, 20-cycle period, 50% duty: outputs follow pwm_in
      // one edge later and dt_active never asserts
      for (int c = 0; c < 80; c++) begin
         logic p;
         p = ((c % 20) < 10);
         drive(0, 1, p, 0);
         tick();
         check("zero_dt", p ? O_HIGH : O_LOW);
      end

      // mid-window change: window starts with 4, dead_time becomes 10
      // during the window, which still ends after 4 cycles
      drive(0, 1, 1, 4);
      tick(); check("mid_dt1", O_DT);
      tick(); check("mid_dt2", O_DT);
      bus.dead_time = 8'd10;
      tick(); check("mid_dt3", O_DT);
      tick(); check("mid_dt4", O_DT);
      tick(); check("mid_end_high", O_HIGH);
      bus.pwm_in = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(); check("next_window_10", O_DT);
      end
      tick(); check("next_window_low", O_LOW);

      // reset mid-window abandons it
      drive(0, 1, 1, 4);
      tick(); check("rst_pre_dt1", O_DT);
      tick(); check("rst_pre_dt2", O_DT);
      rst = 1'b1;
      tick(); check("rst_mid_dt", O_OFF);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(); check("post_rst_dt", O_DT);
      end
      tick(); check("post_rst_high", O_HIGH);

`ifdef TIM_DEADTIME_BREAK_EN
      bus.dead_time = 8'd3;
      bus.break_in  = 1'b1;
      tick(); check("break_in_high", O_FLT);
      bus.break_clr = 1'b1;
      tick(); check("clr_while_break", O_FLT);
      bus.break_clr = 1'b0;
      bus.break_in  = 1'b0;
      tick(); check("fault_latched_en1", O_FLT);
      bus.break_clr = 1'b1;
      tick(); check("fault_cleared_off", O_OFF);
      bus.break_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(); check("resume_dt", O_DT);
      end
      tick(); check("resume_high", O_HIGH);
`else
      bus.break_in  = 1'b1;
      bus.break_clr = 1'b1;
      tick(); check("break_ignored", O_HIGH);
      bus.break_clr = 1'b0;
      tick(); check("break_ignored_hold", O_HIGH);
      bus.break_in  = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/tim_deadtime.md
# tim_deadtime

Dead-time insertion stage placed directly downstream of the `tim` PWM channel. Takes the timer's reference PWM level and drives a complementary high-side/low-side pair, with a programmable both-off window at every transition so the two switches never conduct together. Optional break input forces both outputs off and latches a fault for motor/power-stage protection.

## Interface
- `DT_WIDTH`, 8: width of the dead-time count, in clk cycles.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = stage active; 0 = both outputs forced low.
- `pwm_in`  in  1  reference PWM level from `tim` (`out_p_1`), synchronous to clk.
- `dead_time`  in  DT_WIDTH  both-off window length in cycles; 0 = no window.
- `break_in`  in  1  emergency stop, level-sensitive.
- `break_clr`  in  1  single-cycle pulse that clears a latched fault.
- `out_p`  out  1  high-side drive, registered.
- `out_n`  out  1  low-side drive, registered.
- `dt_active`  out  1  1 while a dead-time window is running.
- `fault`  out  1  latched break indication.

## Operation
- States: OFF, HIGH, LOW, DT, FAULT.
  - OFF: `out_p=0`, `out_n=0`.
  - HIGH: `out_p=1`, `out_n=0`.
  - LOW: `out_p=0`, `out_n=1`.
  - DT: both outputs 0, `dt_active=1`, down-counter running, target level held.
  - FAULT: both outputs 0, `fault=1`.
- OFF with `enable=1`: load counter with `dead_time`, set target = `pwm_in`, enter DT. If `dead_time=0`, go directly to HIGH (target 1) or LOW (target 0).
- HIGH with `pwm_in=0`, or LOW with `pwm_in=1`: enter DT with counter = `dead_time` and target = new level. If `dead_time=0`, switch directly HIGH↔LOW in one edge.
- DT: counter decrements each cycle. When counter = 1, the next edge enters the target state.
- `pwm_in` toggling during DT updates the target without reloading the counter. Pulses shorter than `dead_time` are therefore swallowed, and no shoot-through is possible.
- `dead_time` is sampled only when a window starts. Changing it mid-window has no effect on the current window.
- `enable=0` in any state except FAULT: next edge enters OFF and clears the counter.
- Counter is DT_WIDTH bits; there is no wrap, because it stops at 1.

## Timing
- Reset values: `out_p=0`, `out_n=0`, `dt_active=0`, `fault=0`, state OFF, counter 0.
- Latency: if `pwm_in` changes before edge t, the active output drops at edge t. The opposite output rises at edge t+`dead_time`, or at edge t when `dead_time=0`.
- Low-to-high example: `out_n` falls at edge t; `out_p` rises at edge t+D, where D = `dead_time`. The both-low interval is exactly D cycles.
- Priority order, highest first: `rst` > break (when compiled in) > `enable=0` > `pwm_in` transitions.
- `rst` asserted mid-window: next edge gives reset values, and the window is abandoned.

## Configuration
- `TIM_DEADTIME_BREAK_EN` defined:
  - `break_in=1` sampled at any edge forces both outputs to 0 at that same edge, sets `fault=1`, and enters FAULT.
  - FAULT is left only on an edge where `break_clr=1` and `break_in=0`. It exits to OFF with `fault=0`, then follows `enable` as normal.
  - `enable` has no effect while in FAULT.
- Not defined: `break_in` and `break_clr` are ignored; `fault` is tied to 0; FAULT is unreachable.

## Test plan
- Basic window: reset, `enable=1`, `dead_time=3`, `pwm_in` 0→1 before edge t.
  - `out_n` falls at t; `out_p` rises at t+3.
  - `dt_active=1` for exactly 3 cycles.
- Zero dead time: `dead_time=0`, `pwm_in` period 20 cycles, 50% duty.
  - `out_p` = `pwm_in` delayed 1 edge; `out_n` = its inverse.
  - `dt_active` never asserts.
- Short pulse: `dead_time=5`, 2-cycle high glitch on `pwm_in` while in LOW.
  - `out_n` goes low for 5 cycles and returns high.
  - `out_p` stays 0 throughout.
- Mid-window change: `dead_time=4` at window start, changed to 10 at window cycle 2.
  - Window still ends after 4 cycles; the next window lasts 10.
- Enable/reset interrupt: `enable` drops during HIGH → both outputs 0 next edge. Separately, `rst` pulsed mid-DT → all outputs 0, `fault=0`.
- Break (with `TIM_DEADTIME_BREAK_EN`): `break_in=1` during HIGH.
  - Both outputs 0 and `fault=1` at that edge.
  - `break_clr` while `break_in=1` is ignored.
  - `break_clr` after `break_in=0` → `fault=0`, OFF, then a DT window of `dead_time` cycles before drive resumes.
